// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc - multi-cycle EX-stage ALU
//
// Purpose:
//   Logical, arithmetic, shift and compare ops complete in one cycle.
//   Signed and unsigned multiply (radix-2 shift-add) and divide (restoring)
//   iterate one bit per cycle and write the {hi,lo} pair. All results are
//   registered. The pipeline stalls on !o_ready.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   i_start    issue request, sampled only while o_ready=1
//   i_op       5-bit operation select
//   i_a        operand A / dividend
//   i_b        operand B / divisor / shift source
//   i_shamt    shift amount
//   o_ready    idle, can accept i_start
//   o_done     one-cycle pulse: o_hi/o_lo/o_zero updated
//   o_hi       upper product / remainder (0 for single-cycle ops)
//   o_lo       result / lower product / quotient
//   o_zero     o_lo == 0
//   o_ovf      signed add/sub overflow (only with ALU_MC_OVF_EN)
//
// Build option:
//   ALU_MC_OVF_EN  adds the registered o_ovf output and its overflow logic.
//
// States:
//   S_IDLE | accepting issue; single-cycle ops complete here
//   S_MUL  | one shift-add step per cycle
//   S_DIV  | one restoring-division step per cycle
//   S_FIN  | sign fixup, write {hi,lo}, pulse done
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_zero
`ifdef ALU_MC_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_acc;    // product high half / partial remainder
  logic [WIDTH-1:0] r_mq;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] r_mcand;  // multiplicand / divisor magnitude
  logic             r_neg_p;  // negate product or quotient at FIN
  logic             r_neg_r;  // negate remainder at FIN (dividend sign)
  logic             r_div0;
  logic             r_is_div;

  // ---------------- issue-side decode and single-cycle datapath ----------
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_res;

  assign w_is_mul = (i_op[4:1] == 4'b0011);
  assign w_is_div = (i_op[4:1] == 4'b1000);
  // Signed variants of both mult (0110) and div (10000) have op[0]=0.
  assign w_signed = ~i_op[0];
  assign w_add    = i_a + i_b;
  assign w_sub    = i_a - i_b;
  assign w_abs_a  = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_abs_b  = i_b[WIDTH-1] ? -i_b : i_b;

  always_comb begin
    w_res = '0;
    if (!i_op[4]) begin
      casez (i_op[3:0])
        4'b0000: w_res = i_a & i_b;
        4'b0001: w_res = i_a | i_b;
        4'b0010: w_res = ~(i_a | i_b);
        4'b0011: w_res = i_a ^ i_b;
        4'b0100: w_res = w_add;
        4'b0101: w_res = w_sub;
        4'b1000: w_res = i_b << i_shamt;
        4'b1001: w_res = i_b >> i_shamt;
        4'b101?: w_res = $signed(i_b) >>> i_shamt;
        4'b1100: w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
        4'b1101,
        4'b111?: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
        default: w_res = '0;
      endcase
    end
  end

`ifdef ALU_MC_OVF_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (i_op == 5'b00100)
      w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
    else if (i_op == 5'b00101)
      w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
  end

  assign o_ovf = r_ovf;
`endif

  // ---------------- iterative step datapath -------------------------------
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH-1:0]   w_dsub;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_msum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
  assign w_dshift   = {r_acc, r_mq[WIDTH-1]};
  // Only the low bits of the difference are kept: when the quotient bit is
  // set the true difference is below the divisor and fits in WIDTH bits.
  assign w_dsub     = w_dshift[WIDTH-1:0] - r_mcand;
  assign w_qbit     = (w_dshift >= {1'b0, r_mcand});
  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = r_neg_p ? -w_prod : w_prod;
  assign w_quo      = r_neg_p ? -r_mq : r_mq;
  assign w_rem      = r_neg_r ? -r_acc : r_acc;

  // ---------------- control FSM -------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_mcand  <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
`ifdef ALU_MC_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_is_mul || w_is_div) begin
              r_acc    <= '0;
              r_mq     <= w_signed ? w_abs_a : i_a;
              r_mcand  <= w_signed ? w_abs_b : i_b;
              r_neg_p  <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
              r_neg_r  <= w_signed & i_a[WIDTH-1];
              r_div0   <= w_is_div & (i_b == '0);
              r_is_div <= w_is_div;
              r_cnt    <= CNT_INIT;
              r_ready  <= 1'b0;
              r_state  <= w_is_mul ? S_MUL : S_DIV;
            end else begin
              r_hi   <= '0;
              r_lo   <= w_res;
              r_done <= 1'b1;
`ifdef ALU_MC_OVF_EN
              r_ovf  <= w_ovf;
`endif
            end
          end
        end
        S_MUL: begin
          r_acc <= w_msum[WIDTH:1];
          r_mq  <= {w_msum[0], r_mq[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_FIN;
        end
        S_DIV: begin
          r_acc <= w_qbit ? w_dsub : w_dshift[WIDTH-1:0];
          r_mq  <= {r_mq[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_is_div) begin
            // Divide by zero leaves the dividend magnitude in the remainder,
            // so the dividend-sign fixup already yields hi = a.
            r_hi <= w_rem;
            r_lo <= r_div0 ? '1 : w_quo;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
`ifdef ALU_MC_OVF_EN
          r_ovf   <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_zero  = (r_lo == '0);

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc - scoreboard bench for alu_mc (WIDTH=32)
// Stimulus pushes the hand-computed response and its due cycle; a monitor
// on the falling edge pops and compares whenever o_done is seen.
// ---------------------------------------------------------------------------
module tb_alu_mc;
  localparam int W  = 32;
  localparam int SW = 5;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_NOR   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_MULT  = 5'b00110;
  localparam logic [4:0] OP_MULTU = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01010;
  localparam logic [4:0] OP_SRA2  = 5'b01011;
  localparam logic [4:0] OP_SLT   = 5'b01100;
  localparam logic [4:0] OP_SLTU  = 5'b01101;
  localparam logic [4:0] OP_SLTU3 = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_DIVU  = 5'b10001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [SW-1:0] shamt;
  logic          ready;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          zero;
`ifdef ALU_MC_OVF_EN
  logic          ovf;
`endif

  alu_mc #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_shamt (shamt),
    .o_ready (ready),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_zero  (zero)
`ifdef ALU_MC_OVF_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    int          ecyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: compare on every done; flag a done nobody expected and a done
  // that never came by its due cycle.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_lo"},   64'(lo),   64'(mon_e.lo));
        chk({mon_e.nm, "_hi"},   64'(hi),   64'(mon_e.hi));
        chk({mon_e.nm, "_zero"}, 64'(zero), 64'(mon_e.lo == 32'd0));
        chk({mon_e.nm, "_lat"},  64'(cyc),  64'(mon_e.ecyc));
`ifdef ALU_MC_OVF_EN
        chk({mon_e.nm, "_ovf"},  64'(ovf),  64'(mon_e.ovf));
`endif
      end
    end else if (sb.size() > 0 && cyc >= sb[0].ecyc) begin
      chk({sb[0].nm, "_missing_done"}, 64'(done), 64'd1);
      void'(sb.pop_front());
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after completion is visible.
  task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [4:0] sh,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic eovf, input bit mc, input bit pulse);
    int n;
    op = o; a = aa; b = bb; shamt = sh; start = 1'b1;
    sb.push_back('{nm, ehi, elo, eovf, cyc + (mc ? W + 2 : 1)});
    @(posedge clk); #1;
    start = 1'b0;
    if (!mc) begin
      chk({nm, "_ready"}, 64'(ready), 64'd1);
    end else begin
      n = 0;
      while (!ready && n < 100) begin
        if (pulse) begin
          op = OP_ADD; a = 32'd1; b = 32'd1;
          start = ((n % 8) == 3);
        end
        n++;
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk({nm, "_busy_cycles"}, 64'(n), 64'(W + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nd;
    // Reset, with start asserted to show reset wins.
    rst_n = 1'b0; start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_hi",    64'(hi),    64'd0);
    chk("rst_lo",    64'(lo),    64'd0);
    chk("rst_zero",  64'(zero),  64'd1);
`ifdef ALU_MC_OVF_EN
    chk("rst_ovf",   64'(ovf),   64'd0);
`endif
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, issued back-to-back.
    issue("add",     OP_ADD,   32'd7,         32'd5,         5'd0,  32'd0, 32'd12,         1'b0, 0, 0);
    issue("sub0",    OP_SUB,   32'd5,         32'd5,         5'd0,  32'd0, 32'd0,          1'b0, 0, 0);
    issue("and",     OP_AND,   32'h0000F0F0,  32'h0000FF00,  5'd0,  32'd0, 32'h0000F000,   1'b0, 0, 0);
    issue("or",      OP_OR,    32'h0000F0F0,  32'h0000FF00,  5'd0,  32'd0, 32'h0000FFF0,   1'b0, 0, 0);
    issue("nor",     OP_NOR,   32'd0,         32'd0,         5'd0,  32'd0, 32'hFFFFFFFF,   1'b0, 0, 0);
    issue("xor",     OP_XOR,   32'h0000FF00,  32'h00000FF0,  5'd0,  32'd0, 32'h0000F0F0,   1'b0, 0, 0);
    issue("subwrap", OP_SUB,   32'd0,         32'd1,         5'd0,  32'd0, 32'hFFFFFFFF,   1'b0, 0, 0);
    issue("addovf",  OP_ADD,   32'h7FFFFFFF,  32'd1,         5'd0,  32'd0, 32'h80000000,   1'b1, 0, 0);
    issue("subovf",  OP_SUB,   32'h80000000,  32'd1,         5'd0,  32'd0, 32'h7FFFFFFF,   1'b1, 0, 0);
    issue("sll",     OP_SLL,   32'd0,         32'd1,         5'd31, 32'd0, 32'h80000000,   1'b0, 0, 0);
    issue("srl",     OP_SRL,   32'd0,         32'h80000000,  5'd31, 32'd0, 32'd1,          1'b0, 0, 0);
    issue("sra",     OP_SRA,   32'd0,         32'h80000000,  5'd4,  32'd0, 32'hF8000000,   1'b0, 0, 0);
    issue("sra2",    OP_SRA2,  32'd0,         32'h80000000,  5'd4,  32'd0, 32'hF8000000,   1'b0, 0, 0);
    issue("slt",     OP_SLT,   32'hFFFFFFFF,  32'd1,         5'd0,  32'd0, 32'd1,          1'b0, 0, 0);
    issue("sltu",    OP_SLTU,  32'hFFFFFFFF,  32'd1,         5'd0,  32'd0, 32'd0,          1'b0, 0, 0);
    issue("sltu3",   OP_SLTU3, 32'd1,         32'd2,         5'd0,  32'd0, 32'd1,          1'b0, 0, 0);
    issue("rsv15",   5'b10101, 32'd5,         32'd3,         5'd0,  32'd0, 32'd0,          1'b0, 0, 0);
    issue("rsv1f",   5'b11111, 32'hFFFFFFFF,  32'd3,         5'd2,  32'd0, 32'd0,          1'b0, 0, 0);

    // Multi-cycle ops; the first one also pulses start while busy.
    issue("mult",    OP_MULT,  32'hFFFFFFFD,  32'd7,         5'd0,  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, 1);
    issue("multu",   OP_MULTU, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd0,  32'hFFFFFFFE, 32'h00000001, 1'b0, 1, 0);
    issue("multpos", OP_MULT,  32'h00001234,  32'h00010000,  5'd0,  32'd0,        32'h12340000, 1'b0, 1, 0);
    issue("divmin",  OP_DIV,   32'h80000000,  32'hFFFFFFFF,  5'd0,  32'd0,        32'h80000000, 1'b0, 1, 0);
    issue("divneg",  OP_DIV,   32'hFFFFFFF9,  32'd2,         5'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1, 0);
    issue("divnegb", OP_DIV,   32'd7,         32'hFFFFFFFE,  5'd0,  32'd1,        32'hFFFFFFFD, 1'b0, 1, 0);
    issue("divu",    OP_DIVU,  32'd100,       32'd7,         5'd0,  32'd2,        32'd14,       1'b0, 1, 0);
    issue("div0",    OP_DIV,   32'd5,         32'd0,         5'd0,  32'd5,        32'hFFFFFFFF, 1'b0, 1, 0);
    issue("div0neg", OP_DIV,   32'hFFFFFFFB,  32'd0,         5'd0,  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1, 0);
    issue("divu0",   OP_DIVU,  32'd7,         32'd0,         5'd0,  32'd7,        32'hFFFFFFFF, 1'b0, 1, 0);

    // Reset in cycle 10 of a multiply: aborted, no done, state cleared.
    op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort_busy", 64'(ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_hi",    64'(hi),    64'd0);
    chk("abort_lo",    64'(lo),    64'd0);
    chk("abort_zero",  64'(zero),  64'd1);
    chk("abort_done",  64'(done),  64'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    issue("add_after", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd0, 32'd5, 1'b0, 0, 0);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Same logical, arithmetic, shift and compare ops, plus iterative signed/unsigned multiply and divide writing HI/LO.
- Sits in the EX stage behind a start/ready/done handshake; the pipeline stalls on !ready.
- All results are registered.

Parameters:
- WIDTH, 32, operand/result width; even, >=8.
- SHW, $clog2(WIDTH), shamt width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; sampled only when ready=1
- op  in  5  operation select (see Behaviour)
- a  in  WIDTH  operand A / dividend
- b  in  WIDTH  operand B / divisor / shift source
- shamt  in  SHW  shift amount
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse: hi/lo/zero updated this cycle
- hi  out  WIDTH  upper product / remainder; 0 for single-cycle ops
- lo  out  WIDTH  result / lower product / quotient
- zero  out  1  lo==0, derived from registered lo

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; ready=1, done=0, hi=0, lo=0, zero=1; counter and work registers cleared. Reset wins over start.
- Reset mid-operation aborts: no done pulse, partial result discarded.
- op[4]=0, legacy 4-bit encoding on op[3:0]:
  - 0000 and, 0001 or, 0010 nor, 0011 xor
  - 0100 add, 0101 sub (wrap, no trap)
  - 0110 mult signed, 0111 multu
  - 1000 sll b, 1001 srl b, 101? sra b (all by shamt)
  - 1100 slt signed, 1101/111? sltu
- op[4]=1: 10000 div signed, 10001 divu; all other codes reserved -> hi=lo=0, single-cycle.
- States: IDLE, MUL, DIV, FIN.
- Single-cycle ops: start in IDLE -> at that edge hi=0, lo=result, done=1 next cycle. State stays IDLE, ready stays 1, so back-to-back issue every cycle is legal.
- Mult/div issue: at the start edge, latch |a|,|b| (signed ops) or a,b (unsigned), latch sign flags, counter=WIDTH, ready->0. State -> MUL or DIV.
- MUL: radix-2 shift-add, one multiplier bit per cycle. DIV: restoring, one quotient bit per cycle.
- Counter decrements each cycle; at 0 -> FIN.
- FIN: apply sign fixup, write {hi,lo}, done=1, ready=1, -> IDLE.
- Latency: done is high exactly WIDTH+1 cycles after the start edge; ready is low for exactly WIDTH+1 cycles.
- start while ready=0 is ignored; op/a/b may change freely after issue.
- Signed multiply: negate the 2*WIDTH product iff sign(a)^sign(b).
- Signed divide: quotient negated iff signs differ; remainder takes the dividend's sign; lo=quotient, hi=remainder.
- Divide by zero (b==0, either divide op): lo=all ones, hi=a; normal latency.
- MIN/-1 signed divide: lo=MIN, hi=0, no exception.
- done is 0 in every cycle other than a completion cycle.
- hi/lo hold their value until the next completion or reset.

Optional Feature:
- Macro: ALU_MC_OVF_EN.
- With it: extra output ovf (1 bit), registered, updated on every done. ovf=1 iff op is add/sub and signed overflow occurred, else 0. Reset value 0.
- Without it: port ovf absent and no overflow logic.

Test Plan:
1. add a=7,b=5 -> lo=12, hi=0, done 1 cycle after start, ready stays 1. Then sub a=5,b=5 back-to-back -> lo=0, zero=1. With ALU_MC_OVF_EN, add 0x7FFFFFFF+1 -> ovf=1.
2. mult a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 33 cycles after start; ready low for 33 cycles; start pulses during busy produce no extra done.
3. multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. div a=5,b=0 -> lo=0xFFFFFFFF, hi=5, done at cycle 33.
5. sra b=0x80000000, shamt=4 -> lo=0xF8000000. slt a=0xFFFFFFFF, b=1 -> lo=1. sltu same operands -> lo=0. Reserved op 10101 -> hi=lo=0, zero=1.
6. rst_n=0 on cycle 10 of a mult -> next cycle ready=1, hi=lo=0, zero=1, no done. A following add 2+3 -> lo=5, done next cycle.
